// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the CAM search path.
// The CAM RAM uses the same constants as the search controller.
package cam_pkg;

   localparam int CAM_DATA_W = 4;
   localparam int CAM_ADDR_W = 4;
   localparam int CAM_DEPTH  = 2 ** CAM_ADDR_W;
   localparam int CAM_CNT_W  = CAM_ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_EMIT    = 2'd3
   } cam_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder for the CAM match bitmap.
// Gives the index, a one-hot clear mask, and any-set/exactly-one flags.
module cam_prio_enc #(
   parameter int AW = 4
) (
   input  logic [2**AW-1:0] i_vec,
   output logic [AW-1:0]    o_idx,
   output logic [2**AW-1:0] o_mask,
   output logic             o_any,
   output logic             o_one
);

   localparam int D = 2 ** AW;
   localparam logic [D-1:0] ONE = D'(1);

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      o_idx = '0;
      for (int i = D - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = AW'(i);
      end
   end

   // Two's-complement trick isolates the lowest set bit.
   assign o_mask = i_vec & (~i_vec + ONE);
   assign o_any  = |i_vec;
   assign o_one  = o_any && ((i_vec & (i_vec - ONE)) == '0);

endmodule

// File: rtl/cam_match_reader.sv
// Search-side controller: issues a key to the CAM, captures the match
// bitmap and streams matching addresses lowest first.
module cam_match_reader
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_W,
   parameter int ADDR_WIDTH = CAM_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    s_key,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_WIDTH-1:0]    cam_key,
   input  logic [2**ADDR_WIDTH-1:0] cam_match,
   output logic [ADDR_WIDTH-1:0]    m_addr,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     m_last,
   output logic [ADDR_WIDTH:0]      match_count,
   output logic                     miss,
   output logic                     done
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   cam_state_e              r_state;
   logic [DATA_WIDTH-1:0]   r_cam_key;
   logic [DEPTH-1:0]        r_pending;
   logic [CNT_W-1:0]        r_count;
   logic                    r_miss;
   logic                    r_done;

   logic [ADDR_WIDTH-1:0]   w_idx;
   logic [DEPTH-1:0]        w_mask;
   logic                    w_any;
   logic                    w_one;
   logic [CNT_W-1:0]        w_popcnt;

   cam_prio_enc #(
      .AW (ADDR_WIDTH)
   ) u_enc (
      .i_vec  (r_pending),
      .o_idx  (w_idx),
      .o_mask (w_mask),
      .o_any  (w_any),
      .o_one  (w_one)
   );

   // Population count of the raw bitmap; wide enough for a full hit.
   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_popcnt = w_popcnt + CNT_W'(cam_match[i]);
      end
   end

   // Search FSM: accept, wait for registered CAM read, stream matches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cam_key <= '0;
         r_pending <= '0;
         r_count   <= '0;
         r_miss    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (s_valid) begin
                  r_cam_key <= s_key;
                  r_miss    <= 1'b0;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               r_pending <= cam_match;
               r_count   <= w_popcnt;
               if (w_popcnt == '0) begin
                  r_miss  <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (m_ready) begin
                  r_pending <= r_pending & ~w_mask;
                  if (w_one) begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Stream outputs come straight from state and pending registers.
   assign s_ready     = (r_state == ST_IDLE);
   assign m_valid     = (r_state == ST_EMIT) && w_any;
   assign m_addr      = w_idx;
   assign m_last      = m_valid && w_one;
   assign cam_key     = r_cam_key;
   assign match_count = r_count;
   assign miss        = r_miss;
   assign done        = r_done;

endmodule

// File: tb/tb_cam_match_reader.sv
// Randomized bench for cam_match_reader with a behavioural CAM and
// an address-list reference model.
module tb_cam_match_reader;

   logic        clk;
   logic        rst_n;
   logic [3:0]  s_key;
   logic        s_valid;
   logic        s_ready;
   logic [3:0]  cam_key;
   logic [15:0] cam_match;
   logic [3:0]  m_addr;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic [4:0]  match_count;
   logic        miss;
   logic        done;

   logic [3:0]  mem [16];
   int          n_cmp;
   int          n_bad;

   cam_match_reader #(
      .DATA_WIDTH (4),
      .ADDR_WIDTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_key       (s_key),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .cam_key     (cam_key),
      .cam_match   (cam_match),
      .m_addr      (m_addr),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last),
      .match_count (match_count),
      .miss        (miss),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural CAM: registered compare of the presented key.
   always @(posedge clk) begin
      for (int i = 0; i < 16; i++)
         cam_match[i] <= (mem[i] == cam_key);
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // rmode 0: m_ready random; 1: always high; 2: fixed 0,1,0,1,1 pattern.
   task automatic search(input logic [3:0] key, input int rmode);
      int exp_q [$];
      int idx;
      int cyc;
      int pat [5] = '{0, 1, 0, 1, 1};
      for (int i = 0; i < 16; i++)
         if (mem[i] == key) exp_q.push_back(i);
      chk("s_ready_pre", s_ready, 1);
      s_key   = key;
      s_valid = 1'b1;
      @(negedge clk);
      chk("issue_ready", s_ready, 0);
      chk("issue_key", cam_key, key);
      s_valid = 1'($urandom);
      s_key   = 4'($urandom);
      @(negedge clk);
      chk("capt_valid", m_valid, 0);
      s_valid = 1'($urandom);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         s_valid = 1'b0;
         chk("miss_flag", miss, 1);
         chk("miss_done", done, 1);
         chk("miss_count", match_count, 0);
         chk("miss_valid", m_valid, 0);
         chk("miss_ready", s_ready, 1);
         return;
      end
      idx = 0;
      cyc = 0;
      while (idx < exp_q.size() && cyc < 200) begin
         if (rmode == 1) m_ready = 1'b1;
         else if (rmode == 2) m_ready = (cyc < 5) ? 1'(pat[cyc]) : 1'b1;
         else m_ready = 1'($urandom);
         chk("emit_valid", m_valid, 1);
         chk("emit_addr", m_addr, exp_q[idx]);
         chk("emit_last", m_last, (idx == exp_q.size() - 1) ? 1 : 0);
         chk("emit_count", match_count, exp_q.size());
         chk("emit_done", done, 0);
         if (m_ready) idx++;
         s_valid = (idx == exp_q.size()) ? 1'b0 : 1'($urandom);
         cyc++;
         @(negedge clk);
      end
      chk("emit_bound", (cyc < 200) ? 1 : 0, 1);
      if (rmode == 1) chk("emit_cycles", cyc, exp_q.size());
      m_ready = 1'b0;
      chk("fin_done", done, 1);
      chk("fin_ready", s_ready, 1);
      chk("fin_valid", m_valid, 0);
      chk("fin_miss", miss, 0);
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      s_key   = '0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 4'hF;
      repeat (3) @(negedge clk);
      chk("rst_ready", s_ready, 1);
      chk("rst_key", cam_key, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_addr", m_addr, 0);
      chk("rst_last", m_last, 0);
      chk("rst_count", match_count, 0);
      chk("rst_miss", miss, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Miss, single hit, backpressured triple, full bitmap.
      search(4'h5, 1);
      @(negedge clk);
      mem[7] = 4'hA;
      search(4'hA, 1);
      mem[7] = 4'hF;
      mem[2] = 4'h3; mem[9] = 4'h3; mem[15] = 4'h3;
      search(4'h3, 2);
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      search(4'h0, 1);

      // Reset after the 2nd of 3 addresses.
      for (int i = 0; i < 16; i++) mem[i] = 4'hF;
      mem[1] = 4'h6; mem[4] = 4'h6; mem[12] = 4'h6;
      s_key = 4'h6; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_rst_addr", m_addr, 12);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_addr", m_addr, 0);
      chk("mid_rst_last", m_last, 0);
      chk("mid_rst_ready", s_ready, 1);
      chk("mid_rst_count", match_count, 0);
      chk("mid_rst_key", cam_key, 0);
      @(negedge clk);
      chk("mid_rst_done", done, 0);
      rst_n   = 1'b1;
      m_ready = 1'b0;
      @(negedge clk);
      search(4'h6, 0);

      // Back-to-back: second accepted in the done cycle of the first.
      mem[0] = 4'h1; mem[5] = 4'h2; mem[6] = 4'h2;
      search(4'h1, 1);
      search(4'h2, 0);

      // Randomized searches over a small key space.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 5));
         search(4'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cam_match_reader.md
# cam_match_reader

Search-side controller for the bit-sliced CAM RAM. It accepts a search key, drives it onto the CAM read port, and captures the registered match bitmap one cycle later. It then streams every matching address, lowest first, over a valid/ready interface. It reports the match count and signals a miss or completion, and sits between the CAM RAM's search port and the lookup consumer.

## Interface
- DATA_WIDTH, 4, key width; equals the CAM's data width
- ADDR_WIDTH, 4, address width; CAM depth is 2**ADDR_WIDTH
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- s_key  input  DATA_WIDTH  search key
- s_valid  input  1  search request valid
- s_ready  output  1  high only in IDLE; reset value 1 after release
- cam_key  output  DATA_WIDTH  key to the CAM search port; registered; reset 0
- cam_match  input  2**ADDR_WIDTH  CAM match bitmap; valid one cycle after cam_key changes (registered read)
- m_addr  output  ADDR_WIDTH  matching address; reset 0
- m_valid  output  1  address valid; reset 0
- m_ready  input  1  consumer accepts m_addr
- m_last  output  1  current m_addr is the final match; reset 0
- match_count  output  ADDR_WIDTH+1  number of matches of the last search; reset 0
- miss  output  1  last search found nothing; level; reset 0
- done  output  1  one-cycle completion pulse; reset 0

## Operation
- States: IDLE, ISSUE, CAPTURE, EMIT.
- IDLE: s_ready=1. On s_valid, register s_key into cam_key, clear miss, and go to ISSUE.
- ISSUE: cam_key is stable and the CAM samples it at the end of this cycle. Go to CAPTURE.
- CAPTURE: register cam_match into the pending vector and its popcount into match_count.
  - If the popcount is 0, set miss and done, then go to IDLE.
  - Otherwise go to EMIT.
- EMIT:
  - m_valid=1 and m_addr = index of the lowest set pending bit.
  - m_last=1 when exactly one pending bit remains.
  - On m_valid&&m_ready, clear that bit.
  - If it was the last bit, drop m_valid, pulse done, and go to IDLE. Otherwise present the next index the following cycle.
- m_addr, m_valid and m_last stay stable while m_valid&&!m_ready.
- match_count and miss hold until the next accepted search.
- cam_key holds its last value outside ISSUE/CAPTURE.
- Arithmetic: the popcount is ADDR_WIDTH+1 bits wide, so a full bitmap (2**ADDR_WIDTH) fits without wrap. Priority is lowest index first.
- s_valid outside IDLE is ignored. The request is not queued, and upstream holds it until s_ready.
- The cam_match sampled in CAPTURE is final. CAM writes during EMIT do not alter the pending set.
- rst_n asserted in any state:
  - immediately go to IDLE with pending cleared and all outputs at their reset values;
  - an in-flight stream is dropped without a done pulse.
- rst_n deassertion is synchronized upstream.

## Timing
- Accept at edge 0 (s_valid&&s_ready). ISSUE is cycle 1 and CAPTURE is cycle 2.
- First m_valid in cycle 3. Each further address takes 1 cycle when m_ready is held high.
- Miss: miss=1 and done=1 in cycle 3, s_ready=1 in cycle 3, and the next accept is possible at edge 3.
- Hit with N matches and m_ready always high:
  - last handshake in cycle 2+N;
  - done pulse and s_ready=1 in cycle 3+N.
- Minimum search-to-search spacing: 3 cycles on a miss, 3+N cycles on a hit.
- done is exactly one cycle wide and coincides with the first IDLE cycle.

## Structure
- Shared package/include cam_pkg:
  - state encoding (IDLE=0, ISSUE=1, CAPTURE=2, EMIT=3);
  - CAM_DEPTH = 2**ADDR_WIDTH;
  - count width ADDR_WIDTH+1.
  - The CAM RAM uses the same constants.
- Sub-module cam_prio_enc: combinational lowest-set-bit encoder with a 2**ADDR_WIDTH input. It outputs the index, a one-hot clear mask, any-set and exactly-one flags.
- Popcount and FSM stay in cam_match_reader.

## Test plan
- Miss: CAM has no entry for key 0x5, search 0x5 → cycle 3 shows miss=1, done=1, match_count=0, and m_valid is never asserted.
- Single hit: address 7 written with key 0xA, search 0xA → cycle 3 shows m_addr=7, m_valid=1, m_last=1 and match_count=1. The cycle after the handshake shows done=1.
- Multiple hits with backpressure: addresses 2, 9 and 15 hold key 0x3, and m_ready toggles 0,1,0,1,1.
  - Addresses come out in order 2, 9, 15 and are held stable while m_ready=0.
  - m_last is high only with 15, and match_count=3.
- Full bitmap: all 16 addresses hold key 0x0 and m_ready=1 → addresses 0..15 on consecutive cycles, match_count=16 (5'b10000), and done in cycle 19.
- Reset mid-stream: assert rst_n low after the 2nd of 3 addresses → all outputs are 0 and s_ready=1 at once with no done pulse. A new search after release behaves normally.
- Back-to-back requests: s_valid held high with keys 0x1 then 0x2 → the second key is accepted in the done cycle of the first, and s_valid during ISSUE, CAPTURE and EMIT has no effect.
